// File: rtl/servo_pwm.sv
// servo_pwm: hobby-servo PWM frame generator with a double-buffered pulse width.
//
// A free-running frame counter produces one frame every PERIOD_CYCLES clocks
// while en is high. A width written with load is clamped to the servo range and
// parked in a shadow register. It takes effect only at the next frame boundary,
// so a pulse is never cut short or stretched mid-frame.
//
// Ports:
//   clk         - single clock, all state changes on its rising edge
//   clr         - synchronous active-high reset; overrides en and load
//   en          - frame generator enable; low holds the counter at 0
//   load        - one-cycle strobe that captures duty_in
//   duty_in     - requested pulse width in cycles
//   pwm_out     - registered servo pulse
//   frame_start - registered one-cycle pulse following each frame boundary
//   width_out   - pulse width in force for the current frame
//   pending     - a loaded width is waiting for the next frame boundary
//   clamp_flag  - one-cycle pulse after a load that had to be clamped
module servo_pwm #(
  parameter int unsigned PERIOD_CYCLES = 1000000,
  parameter int unsigned MIN_PULSE     = 50000,
  parameter int unsigned MAX_PULSE     = 100000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] duty_in,
  output logic        pwm_out,
  output logic        frame_start,
  output logic [31:0] width_out,
  output logic        pending,
  output logic        clamp_flag
);

  localparam logic [31:0] CNT_LAST = 32'(PERIOD_CYCLES - 1);
  localparam logic [31:0] MIN_W    = 32'(MIN_PULSE);
  localparam logic [31:0] MAX_W    = 32'(MAX_PULSE);

  logic [31:0] cnt_reg, cnt_next;
  logic [31:0] shadow_reg, shadow_next;
  logic [31:0] width_reg, width_next;
  logic        pending_reg, pending_next;
  logic        pwm_reg, pwm_next;
  logic        frame_start_reg, frame_start_next;
  logic        clamp_reg, clamp_next;

  logic        boundary;
  logic [31:0] clamped;
  logic        out_of_range;
  logic [31:0] active_width;

  // Zero is a legal "servo idle" request and passes through unclamped.
  always_comb begin
    clamped      = duty_in;
    out_of_range = 1'b0;
    if (duty_in != 32'd0 && duty_in < MIN_W) begin
      clamped      = MIN_W;
      out_of_range = 1'b1;
    end else if (duty_in > MAX_W) begin
      clamped      = MAX_W;
      out_of_range = 1'b1;
    end
  end

  assign boundary = en && (cnt_reg == 32'd0);

  // The width governing the frame that starts this cycle: a pending shadow
  // value is promoted here, so the pulse decision at cnt=0 already sees it.
  assign active_width = (boundary && pending_reg) ? shadow_reg : width_reg;

  always_comb begin
    cnt_next = 32'd0;
    if (en) begin
      cnt_next = (cnt_reg == CNT_LAST) ? 32'd0 : cnt_reg + 32'd1;
    end

    // A load in the boundary cycle is stored for the following frame; the
    // boundary itself consumes the shadow value that was already there.
    shadow_next  = load ? clamped : shadow_reg;
    pending_next = load ? 1'b1 : (boundary ? 1'b0 : pending_reg);
    width_next   = active_width;

    pwm_next         = en && (cnt_reg < active_width);
    frame_start_next = boundary;
    clamp_next       = load && out_of_range;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_reg         <= 32'd0;
      shadow_reg      <= 32'd0;
      width_reg       <= 32'd0;
      pending_reg     <= 1'b0;
      pwm_reg         <= 1'b0;
      frame_start_reg <= 1'b0;
      clamp_reg       <= 1'b0;
    end else begin
      cnt_reg         <= cnt_next;
      shadow_reg      <= shadow_next;
      width_reg       <= width_next;
      pending_reg     <= pending_next;
      pwm_reg         <= pwm_next;
      frame_start_reg <= frame_start_next;
      clamp_reg       <= clamp_next;
    end
  end

  assign pwm_out     = pwm_reg;
  assign frame_start = frame_start_reg;
  assign width_out   = width_reg;
  assign pending     = pending_reg;
  assign clamp_flag  = clamp_reg;

endmodule

// File: tb/tb_servo_pwm.sv
module tb_servo_pwm;

  logic        clk;
  logic        clr;
  logic        en;
  logic        load;
  logic [31:0] duty_in;
  logic        pwm_out;
  logic        frame_start;
  logic [31:0] width_out;
  logic        pending;
  logic        clamp_flag;

  int checks   = 0;
  int failures = 0;

  servo_pwm #(
    .PERIOD_CYCLES(20),
    .MIN_PULSE    (4),
    .MAX_PULSE    (8)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .load       (load),
    .duty_in    (duty_in),
    .pwm_out    (pwm_out),
    .frame_start(frame_start),
    .width_out  (width_out),
    .pending    (pending),
    .clamp_flag (clamp_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step until frame_start is seen (bounded).
  task automatic wait_fs(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (frame_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Called while frame_start is high; measures one frame up to the next
  // frame_start sample. contig is 0 if pwm rises again after falling.
  task automatic measure_frame(output int high, output int len, output bit contig);
    bit fell;
    high   = 0;
    len    = 0;
    contig = 1'b1;
    fell   = 1'b0;
    do begin
      if (pwm_out === 1'b1) begin
        high++;
        if (fell) contig = 1'b0;
      end else begin
        fell = 1'b1;
      end
      len++;
      tick();
    end while (frame_start !== 1'b1 && len < 40);
  endtask

  task automatic test_reset();
    clr = 1'b1; en = 1'b0; load = 1'b1; duty_in = 32'd6;
    tick();
    tick();
    checks++;
    if ({pwm_out, frame_start, pending, clamp_flag} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags actual=%b required=0000", {pwm_out, frame_start, pending, clamp_flag});
    end
    checks++;
    if (width_out !== 32'd0) begin
      failures++;
      $display("FAIL reset_width actual=%0d required=0", width_out);
    end
    clr = 1'b0; load = 1'b0;
    tick();
    checks++;
    if (pending !== 1'b0) begin
      failures++;
      $display("FAIL reset_load_discarded pending actual=%b required=0", pending);
    end
    $display("test_reset: clr with concurrent load -> all outputs zero");
  endtask

  task automatic test_basic();
    int high, len;
    bit contig, found;
    en = 1'b1; load = 1'b1; duty_in = 32'd6;
    tick();
    load = 1'b0;
    checks++;
    if (pending !== 1'b1 || width_out !== 32'd0 || clamp_flag !== 1'b0) begin
      failures++;
      $display("FAIL basic_load pending=%b width=%0d clamp=%b required pending=1 width=0 clamp=0",
               pending, width_out, clamp_flag);
    end
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("FAIL basic_first_frame_start actual=%b required=1", frame_start);
    end
    measure_frame(high, len, contig);
    checks++;
    if (high !== 0 || len !== 20) begin
      failures++;
      $display("FAIL basic_idle_frame high=%0d len=%0d required high=0 len=20", high, len);
    end
    checks++;
    if (width_out !== 32'd6 || pending !== 1'b0) begin
      failures++;
      $display("FAIL basic_apply width=%0d pending=%b required width=6 pending=0", width_out, pending);
    end
    for (int f = 0; f < 2; f++) begin
      measure_frame(high, len, contig);
      checks++;
      if (high !== 6 || len !== 20 || contig !== 1'b1) begin
        failures++;
        $display("FAIL basic_frame%0d high=%0d len=%0d contig=%b required high=6 len=20 contig=1",
                 f, high, len, contig);
      end
    end
    found = 1'b1;
    $display("test_basic: width 6 applied, pulse 6 of 20 cycles");
  endtask

  task automatic test_clamp(input logic [31:0] duty, input int exp_w);
    int high, len;
    bit contig, found;
    load = 1'b1; duty_in = duty;
    tick();
    load = 1'b0;
    checks++;
    if (clamp_flag !== 1'b1) begin
      failures++;
      $display("FAIL clamp_flag_set duty=%0d actual=%b required=1", duty, clamp_flag);
    end
    tick();
    checks++;
    if (clamp_flag !== 1'b0) begin
      failures++;
      $display("FAIL clamp_flag_clear duty=%0d actual=%b required=0", duty, clamp_flag);
    end
    wait_fs(found);
    checks++;
    if (!found || width_out !== 32'(exp_w)) begin
      failures++;
      $display("FAIL clamp_width duty=%0d found=%b actual=%0d required=%0d", duty, found, width_out, exp_w);
    end
    measure_frame(high, len, contig);
    checks++;
    if (high !== exp_w || len !== 20) begin
      failures++;
      $display("FAIL clamp_frame duty=%0d high=%0d len=%0d required high=%0d len=20", duty, high, len, exp_w);
    end
    $display("test_clamp: duty=%0d -> width %0d", duty, exp_w);
  endtask

  task automatic test_back_to_back();
    int high, len;
    bit contig, found;
    repeat (3) tick();
    load = 1'b1; duty_in = 32'd5;
    tick();
    duty_in = 32'd7;
    tick();
    load = 1'b0;
    checks++;
    if (pending !== 1'b1 || width_out !== 32'd8) begin
      failures++;
      $display("FAIL b2b_pending pending=%b width=%0d required pending=1 width=8", pending, width_out);
    end
    wait_fs(found);
    checks++;
    if (!found || width_out !== 32'd7) begin
      failures++;
      $display("FAIL b2b_width found=%b actual=%0d required=7", found, width_out);
    end
    measure_frame(high, len, contig);
    checks++;
    if (high !== 7) begin
      failures++;
      $display("FAIL b2b_frame high=%0d required=7", high);
    end
    $display("test_back_to_back: loads 5 then 7 -> width 7");
  endtask

  task automatic test_load_at_boundary();
    int high, len;
    bit contig;
    // At a frame_start sample the counter reads 1.
    load = 1'b1; duty_in = 32'd5;
    tick();
    load = 1'b0;
    repeat (18) tick();
    // Now in the boundary cycle (cnt=0); width 7 is in force, shadow 5 pending.
    checks++;
    if (frame_start !== 1'b0 || pending !== 1'b1) begin
      failures++;
      $display("FAIL lab_pre frame_start=%b pending=%b required frame_start=0 pending=1", frame_start, pending);
    end
    load = 1'b1; duty_in = 32'd7;
    tick();
    load = 1'b0;
    checks++;
    if (frame_start !== 1'b1 || width_out !== 32'd5 || pending !== 1'b1) begin
      failures++;
      $display("FAIL lab_boundary frame_start=%b width=%0d pending=%b required 1/5/1",
               frame_start, width_out, pending);
    end
    measure_frame(high, len, contig);
    checks++;
    if (high !== 5 || len !== 20) begin
      failures++;
      $display("FAIL lab_frame5 high=%0d len=%0d required high=5 len=20", high, len);
    end
    checks++;
    if (width_out !== 32'd7 || pending !== 1'b0) begin
      failures++;
      $display("FAIL lab_next width=%0d pending=%b required width=7 pending=0", width_out, pending);
    end
    measure_frame(high, len, contig);
    checks++;
    if (high !== 7) begin
      failures++;
      $display("FAIL lab_frame7 high=%0d required=7", high);
    end
    $display("test_load_at_boundary: frame uses 5, following frame 7");
  endtask

  task automatic test_clr_mid_pulse();
    int highs, starts;
    bit found;
    load = 1'b1; duty_in = 32'd8;
    tick();
    load = 1'b0;
    wait_fs(found);
    checks++;
    if (!found || width_out !== 32'd8) begin
      failures++;
      $display("FAIL clr_setup found=%b width=%0d required=8", found, width_out);
    end
    tick();
    tick();
    // cnt=3, mid-pulse
    checks++;
    if (pwm_out !== 1'b1) begin
      failures++;
      $display("FAIL clr_midpulse pwm actual=%b required=1", pwm_out);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (pwm_out !== 1'b0 || width_out !== 32'd0 || pending !== 1'b0) begin
      failures++;
      $display("FAIL clr_effect pwm=%b width=%0d pending=%b required 0/0/0", pwm_out, width_out, pending);
    end
    highs = 0; starts = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (pwm_out === 1'b1) highs++;
      if (frame_start === 1'b1) starts++;
    end
    checks++;
    if (highs !== 0 || starts !== 3) begin
      failures++;
      $display("FAIL clr_after highs=%0d starts=%0d required highs=0 starts=3", highs, starts);
    end
    $display("test_clr_mid_pulse: pulse aborted, idle until next load");
  endtask

  task automatic test_en_drop();
    int high, len, bad;
    bit contig, found;
    load = 1'b1; duty_in = 32'd4;
    tick();
    load = 1'b0;
    wait_fs(found);
    checks++;
    if (!found || width_out !== 32'd4) begin
      failures++;
      $display("FAIL en_setup found=%b width=%0d required=4", found, width_out);
    end
    repeat (9) tick();
    en = 1'b0;
    tick();
    checks++;
    if (pwm_out !== 1'b0 || frame_start !== 1'b0) begin
      failures++;
      $display("FAIL en_off pwm=%b frame_start=%b required 0/0", pwm_out, frame_start);
    end
    load = 1'b1; duty_in = 32'd6;
    tick();
    load = 1'b0;
    checks++;
    if (pending !== 1'b1 || width_out !== 32'd4) begin
      failures++;
      $display("FAIL en_off_load pending=%b width=%0d required pending=1 width=4", pending, width_out);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (pwm_out !== 1'b0 || frame_start !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL en_off_idle active_samples=%0d required=0", bad);
    end
    en = 1'b1;
    tick();
    checks++;
    if (frame_start !== 1'b1 || width_out !== 32'd6 || pending !== 1'b0) begin
      failures++;
      $display("FAIL en_restart frame_start=%b width=%0d pending=%b required 1/6/0",
               frame_start, width_out, pending);
    end
    measure_frame(high, len, contig);
    checks++;
    if (high !== 6 || len !== 20 || contig !== 1'b1) begin
      failures++;
      $display("FAIL en_restart_frame high=%0d len=%0d contig=%b required 6/20/1", high, len, contig);
    end
    $display("test_en_drop: abort and restart with width 6");
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; load = 1'b0; duty_in = 32'd0;
    test_reset();
    test_basic();
    test_clamp(32'd2, 4);
    test_clamp(32'd50, 8);
    test_back_to_back();
    test_load_at_boundary();
    test_clr_mid_pulse();
    test_en_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_pwm.md
SERVO_PWM -- requirements
Module: servo_pwm

Interface
REQ-001 Parameter PERIOD_CYCLES, default 1000000, SHALL set the clock cycles per PWM frame (20 ms at 50 MHz).
REQ-002 Parameter MIN_PULSE, default 50000, SHALL set the minimum nonzero pulse width in cycles (1 ms).
REQ-003 Parameter MAX_PULSE, default 100000, SHALL set the maximum pulse width in cycles (2 ms).
REQ-004 Ports SHALL be as follows, one per line:
  clk           input   1   single clock; all state changes on its rising edge
  clr           input   1   synchronous, active-high reset
  en            input   1   frame generator enable
  load          input   1   one-cycle strobe: capture duty_in
  duty_in       input   32  requested pulse width in cycles, fed from the upstream 32-bit register output
  pwm_out       output  1   registered servo pulse
  frame_start   output  1   registered one-cycle pulse at each frame start
  width_out     output  32  pulse width in force for the current frame
  pending       output  1   a loaded width awaits the next frame boundary
  clamp_flag    output  1   one-cycle pulse: the last load was clamped
REQ-005 One clock (clk); reset clr is synchronous and active-high; no other reset or clock SHALL exist.

Function
REQ-006 Internal 32-bit frame counter cnt SHALL count 0..PERIOD_CYCLES-1 and wrap to 0 while en=1.
REQ-007 While en=0, cnt SHALL be held at 0, and pwm_out and frame_start SHALL be 0 from the next edge.
REQ-008 A frame boundary SHALL be every cycle in which en=1 and cnt=0.
REQ-009 On load=1, the shadow register SHALL capture clamp(duty_in) and pending SHALL be set to 1 on the next edge.
REQ-010 clamp(x) SHALL be: 0 if x=0; MIN_PULSE if 0<x<MIN_PULSE; MAX_PULSE if x>MAX_PULSE; otherwise x (unsigned compare).
REQ-011 clamp_flag SHALL be 1 for exactly the cycle after a load whose duty_in was nonzero and outside [MIN_PULSE, MAX_PULSE]; otherwise 0.
REQ-012 At a frame boundary with pending=1, width_out SHALL take the shadow value and pending SHALL clear on the same edge.
REQ-013 Load coinciding with a frame boundary: the boundary SHALL use the pre-existing shadow value; the new value SHALL be stored with pending=1 for the next boundary.
REQ-014 Back-to-back loads before a boundary: the last load SHALL win; earlier values SHALL be discarded.
REQ-015 width_out SHALL change only at a frame boundary or on reset.
REQ-016 pwm_out SHALL be registered as (en=1 and cnt < active width), where active width is the value in force for that frame; pwm_out is high for exactly width_out cycles, starting the cycle after the boundary.
REQ-017 width_out=0 SHALL hold pwm_out low for the whole frame (servo idle).
REQ-018 frame_start SHALL be 1 for the single cycle after each frame boundary.
REQ-019 Deasserting en mid-frame SHALL abort the frame; re-asserting en SHALL start a fresh frame at cnt=0 and SHALL apply pending at that boundary.
REQ-020 Pulse width never exceeds MAX_PULSE < PERIOD_CYCLES, so pwm_out SHALL be low for at least one cycle per frame.

Reset
REQ-021 With clr=1 at an edge: cnt=0, shadow=0, width_out=0, pending=0, pwm_out=0, frame_start=0, clamp_flag=0.
REQ-022 clr SHALL take priority over load and en in the same cycle; a load concurrent with clr SHALL be discarded.
REQ-023 clr asserted mid-pulse SHALL force pwm_out to 0 on the next edge; after release, generation SHALL restart at cnt=0 with width 0 until a load is applied.

Verification (PERIOD_CYCLES=20, MIN_PULSE=4, MAX_PULSE=8)
REQ-024 Reset, en=1, load duty_in=6 -> pending=1; at the next boundary width_out=6, pending=0; pwm_out high 6 cycles, low 14 cycles per frame; frame_start every 20 cycles.
REQ-025 load duty_in=2, then load duty_in=50 -> clamp_flag pulses after each; the frames after the respective boundaries use widths 4 and 8.
REQ-026 Load 5 mid-frame, then load 7 before the boundary -> next frame width 7; 5 is never applied.
REQ-027 Load 7 exactly in the boundary cycle while the shadow holds 5 -> that frame uses 5, the following frame uses 7.
REQ-028 clr asserted at cnt=3 during an 8-cycle pulse -> pwm_out=0 and width_out=0 on the next edge; after release, pwm_out stays 0 until a load plus boundary.
REQ-029 en dropped at cnt=10, load 6 while en=0, en raised -> pwm_out=0 during en=0; the first frame after re-enable starts at cnt=0 with width 6.
